if_stage: RTL

- Instruction-fetch stage for the pipelined MIPS core.
- Owns the PC register and drives the instruction-memory address.
- Selects the next PC from the sequential path or a redirect supplied by decode.
- Holds the IF/ID pipeline register that feeds the decode/register-read stage. Supports stall, flush and fetch-address-error detection.

---
 rtl/if_stage.sv | 88 ++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the IM address and
// holds the IF/ID pipeline register, with stall, flush and fetch-error flagging.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] im_instr,
    output logic [31:0] im_addr,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic        adel_d
);

    // Window bounds held in 33 bits so PC_RESET + 4*IM_WORDS cannot wrap.
    localparam logic [32:0] LP_LOW  = {1'b0, PC_RESET};
    localparam logic [32:0] LP_HIGH = {1'b0, PC_RESET} + (33'(IM_WORDS) << 2);

    logic [31:0] r_pc_f;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic        r_valid_d;
    logic        r_adel_d;

    logic [32:0] w_pc_ext;
    logic        w_misaligned;
    logic        w_below;
    logic        w_above;
    logic        w_fetch_err;
    logic [31:0] w_pc_next;

    assign w_pc_ext     = {1'b0, r_pc_f};
    assign w_misaligned = (r_pc_f[1:0] != 2'b00);
    assign w_below      = (w_pc_ext < LP_LOW);
    assign w_above      = (w_pc_ext >= LP_HIGH);
    assign w_fetch_err  = w_misaligned | w_below | w_above;

    // Redirect targets are taken as-is; a bad target is flagged when fetched.
    assign w_pc_next = redirect_valid ? redirect_pc : (r_pc_f + 32'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_f <= PC_RESET;
        end else if (!stall) begin
            r_pc_f <= w_pc_next;
        end
    end

    // Stall outranks flush, so a flush raised during a stall is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_d <= 32'd0;
            r_pc_d    <= PC_RESET;
            r_valid_d <= 1'b0;
            r_adel_d  <= 1'b0;
        end else if (stall) begin
            r_instr_d <= r_instr_d;
            r_pc_d    <= r_pc_d;
            r_valid_d <= r_valid_d;
            r_adel_d  <= r_adel_d;
        end else if (flush) begin
            r_instr_d <= 32'd0;
            r_pc_d    <= r_pc_f;
            r_valid_d <= 1'b0;
            r_adel_d  <= 1'b0;
        end else begin
            r_instr_d <= w_fetch_err ? 32'd0 : im_instr;
            r_pc_d    <= r_pc_f;
            r_valid_d <= 1'b1;
            r_adel_d  <= w_fetch_err;
        end
    end

    assign im_addr = r_pc_f;
    assign instr_d = r_instr_d;
    assign pc_d    = r_pc_d;
    assign pc8_d   = r_pc_d + 32'd8;
    assign valid_d = r_valid_d;
    assign adel_d  = r_adel_d;

endmodule
